// File: rtl/a_and_b.sv
// Two-input AND with a combinational output and a registered output that can
// sit behind an optional per-input flop chain of SYNC_STAGES stages.
module a_and_b #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pi_a,
    input  logic pi_b,
    output logic po_c1,
    output logic po_c2
);

    generate
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_cfg
            $error("a_and_b: SYNC_STAGES=%0d outside legal range 0..3", SYNC_STAGES);
        end
    endgenerate

    assign po_c1 = pi_a & pi_b;

    logic a_s;
    logic b_s;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign a_s = pi_a;
            assign b_s = pi_b;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] a_q, b_q;
            logic [SYNC_STAGES-1:0] a_d, b_d;

            always_comb begin
                a_d    = '0;
                b_d    = '0;
                a_d[0] = pi_a;
                b_d[0] = pi_b;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    a_d[i] = a_q[i-1];
                    b_d[i] = b_q[i-1];
                end
            end

            // Every stage clears on reset so nothing captured before reset can reach po_c2.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign a_s = a_q[SYNC_STAGES-1];
            assign b_s = b_q[SYNC_STAGES-1];
        end
    endgenerate

    logic c2_d;
    logic c2_q;

    assign c2_d = a_s & b_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c2_q <= 1'b0;
        end else begin
            c2_q <= c2_d;
        end
    end

    assign po_c2 = c2_q;

endmodule

// File: tb/tb_a_and_b.sv
// Directed and randomised checks of a_and_b with SYNC_STAGES = 0, 2 and 3
// instances sharing the same clock, reset and operands.
`timescale 1ns/1ps
module tb_a_and_b;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c1_0, c2_0, c1_2, c2_2, c1_3, c2_3;

    int n_assert = 0;
    int n_fail   = 0;

    a_and_b #(.SYNC_STAGES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .pi_a(a), .pi_b(b), .po_c1(c1_0), .po_c2(c2_0));
    a_and_b #(.SYNC_STAGES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .pi_a(a), .pi_b(b), .po_c1(c1_2), .po_c2(c2_2));
    a_and_b #(.SYNC_STAGES(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .pi_a(a), .pi_b(b), .po_c1(c1_3), .po_c2(c2_3));

    // Rising edges at 10, 30, 50, ... ns
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_c1(input string tag, input logic exp);
        chk({tag, "_c1_s0"}, c1_0, exp);
        chk({tag, "_c1_s2"}, c1_2, exp);
        chk({tag, "_c1_s3"}, c1_3, exp);
    endtask

    logic tt_a [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic tt_b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_q [4];
    longint t;
    int edges;

    initial begin
        // Reset state
        #5;
        chk("rst_c2_s0", c2_0, 1'b0);
        chk("rst_c2_s2", c2_2, 1'b0);
        chk("rst_c2_s3", c2_3, 1'b0);
        chk_c1("rst", 1'b0);
        @(posedge clk); #1;
        chk("rst_edge_c2_s0", c2_0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table on the zero-stage instance
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = tt_a[i];
            b = tt_b[i];
            #1;
            chk_c1($sformatf("tt%0d", i), tt_a[i] & tt_b[i]);
            @(posedge clk); #1;
            chk($sformatf("tt%0d_c2_s0", i), c2_0, tt_a[i] & tt_b[i]);
        end

        // Short pulse on b between edges must not reach po_c2
        @(posedge clk); #2;
        a = 1'b1; b = 1'b0;
        @(posedge clk); #1;
        chk("pulse_pre_c2_s0", c2_0, 1'b0);
        #4 b = 1'b1;
        #1 chk_c1("pulse_hi", 1'b1);
        #2 b = 1'b0;
        #1 chk_c1("pulse_lo", 1'b0);
        @(posedge clk); #1;
        chk("pulse_c2_s0", c2_0, 1'b0);

        // Asynchronous reset in mid-cycle
        b = 1'b1;
        @(posedge clk); #1;
        chk("ar_pre_c2_s0", c2_0, 1'b1);
        #4 rst_n = 1'b0;
        #1;
        chk("ar_c2_s0", c2_0, 1'b0);
        chk_c1("ar", 1'b1);
        @(posedge clk); #1;
        chk("ar_hold_c2_s0", c2_0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ar_rel_c2_s0", c2_0, 1'b0);
        @(posedge clk); #1;
        chk("ar_resume_c2_s0", c2_0, 1'b1);

        // Latency: clear pipelines, then step a=b to 1 just after an edge
        a = 1'b0; b = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("lat_idle_c2_s2", c2_2, 1'b0);
        chk("lat_idle_c2_s3", c2_3, 1'b0);
        a = 1'b1; b = 1'b1;
        #1 chk_c1("lat", 1'b1);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            chk($sformatf("lat_e%0d_c2_s0", e), c2_0, 1'b1);
            chk($sformatf("lat_e%0d_c2_s2", e), c2_2, (e >= 3) ? 1'b1 : 1'b0);
            chk($sformatf("lat_e%0d_c2_s3", e), c2_3, (e >= 4) ? 1'b1 : 1'b0);
        end

        // Reset with a pipeline full of 1s, then inputs 0: no stale 1 may appear
        @(posedge clk); #1;
        chk("rp_full_c2_s3", c2_3, 1'b1);
        rst_n = 1'b0;
        #1 chk("rp_rst_c2_s3", c2_3, 1'b0);
        @(posedge clk); #1;
        a = 1'b0; b = 1'b0;
        #2 rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            chk($sformatf("rp_e%0d_c2_s3", e), c2_3, 1'b0);
            chk($sformatf("rp_e%0d_c2_s2", e), c2_2, 1'b0);
        end

        // Random soak: a changes at 10n+5 ns, b at 15n+3 ns, never on a clock edge
        for (int k = 0; k < 4; k++) exp_q[k] = 1'b0;
        edges = 0;
        while (edges < 10000) begin
            #1;
            t = $time;
            if (t % 10 == 5) a = 1'($urandom);
            if (t % 15 == 3) b = 1'($urandom);
            if (t % 20 == 9) begin
                for (int k = 3; k > 0; k--) exp_q[k] = exp_q[k-1];
                exp_q[0] = a & b;
            end
            if (t % 20 == 11) begin
                edges++;
                chk("soak_c2_s0", c2_0, exp_q[0]);
                chk("soak_c2_s2", c2_2, exp_q[2]);
                chk("soak_c2_s3", c2_3, exp_q[3]);
            end
            if (t % 10 == 6 || t % 15 == 4) chk("soak_c1_s0", c1_0, a & b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/a_and_b.md
A_AND_B -- requirements
Module: a_and_b

Interface
REQ-001 Parameter SYNC_STAGES, default 0, number of input pipeline stages ahead of the registered AND (legal 0..3).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 pi_a  input  1  operand A.
REQ-005 pi_b  input  1  operand B.
REQ-006 po_c1  output  1  combinational AND of pi_a and pi_b.
REQ-007 po_c2  output  1  registered AND of pi_a and pi_b.

Function
REQ-008 po_c1 SHALL equal pi_a AND pi_b at all times, with zero clock latency, no state and no dependence on clk or rst_n.
REQ-009 po_c1 SHALL track any input change within the same simulation time step; no glitch filtering.
REQ-010 With SYNC_STAGES=0, po_c2 SHALL take the value (pi_a AND pi_b) sampled at each rising clk edge, holding it until the next edge; latency 1 cycle.
REQ-011 With SYNC_STAGES=N>0, pi_a and pi_b SHALL each pass through an N-deep chain of flops before the AND register; po_c2 latency = N+1 rising edges.
REQ-012 Input changes between clock edges SHALL NOT affect po_c2; only values present at the rising edge are captured.
REQ-013 An input change coincident with a clock edge SHALL be captured by a 0-delay flop model as the pre-edge value, per standard nonblocking semantics.
REQ-014 po_c2 SHALL be driven directly from a flop output; no combinational logic after the register.
REQ-015 SYNC_STAGES outside 0..3 SHALL be treated as a configuration error, flagged at elaboration; no silent clamping.
REQ-016 X or Z on an input SHALL propagate per standard AND semantics; no sanitizing (a 0 on the other input forces 0).

Reset
REQ-017 rst_n low SHALL immediately, without waiting for clk, force po_c2 and every pipeline stage flop to 0.
REQ-018 While rst_n is low, po_c2 SHALL stay 0 regardless of clk and inputs; po_c1 SHALL continue to follow REQ-008.
REQ-019 After rst_n rises, the first rising clk edge SHALL resume normal capture; po_c2 reflects real inputs after SYNC_STAGES+1 edges, 0 before that.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight pipeline contents; no pre-reset value ever appears on po_c2 after release.
REQ-021 Synchronizing rst_n deassertion is outside this block; the block SHALL accept rst_n already released synchronously to clk.

Verification
REQ-022 Truth table, SYNC_STAGES=0: apply (a,b)=00,01,10,11 each for one full cycle -> po_c1 = 0,0,0,1 immediately; po_c2 = 0,0,0,1, each one edge later.
REQ-023 Mid-cycle pulse: a=1, b pulses 1 for 3 ns between edges (20 ns clock) -> po_c1 pulses 1 for 3 ns; po_c2 stays 0.
REQ-024 Async reset: a=b=1 with po_c2=1, drop rst_n mid-cycle -> po_c2=0 at the same time step, po_c1 stays 1; release rst_n -> po_c2=1 after the next rising edge.
REQ-025 Latency, SYNC_STAGES=2: step a=b from 0 to 1 just after an edge -> po_c2 rises on the 3rd following rising edge; po_c1 rises at once.
REQ-026 Random soak: toggle a every 10 ns and b every 15 ns from $random with a 20 ns clock for 10,000 cycles -> po_c1 always equals a&b; po_c2 equals a&b sampled SYNC_STAGES+1 edges earlier, checked by a scoreboard.
REQ-027 Reset mid-pipeline, SYNC_STAGES=3: load 1s, assert rst_n for one cycle, then inputs=0 -> po_c2 never returns to 1.
